// File: rtl/riscv_ppr_pkg.sv
// riscv_ppr_pkg: shared types, constants and helpers for the skid-buffer pipeline register
package riscv_ppr_pkg;
  typedef enum logic [1:0] {PPR_EMPTY, PPR_ONE, PPR_FULL} ppr_state_e;
  localparam int PPR_SLICE_CAP = 2;
  function automatic int ppr_occ_w(input int stages);
    return $clog2(PPR_SLICE_CAP * stages + 1);
  endfunction
endpackage

// File: rtl/riscv_ppr_skid_slice.sv
// riscv_ppr_skid_slice: one 2-entry skid slice; RISCV_PPR_BUBBLE_ZERO_EN zeroes payloads of invalid entries
module riscv_ppr_skid_slice
  import riscv_ppr_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_out
);
  logic              m_v, s_v, push, pop, m_ld, s_ld, s_mv, m_v_n, s_v_n;
  logic [DATA_W-1:0] m_d, s_d, m_d_n, s_d_n;
  ppr_state_e        st;
  assign ready_out = ~s_v;
  assign valid_out = m_v;
  assign data_out  = m_d;
  // next state: flush dominates, skid drains into main on pop, input loads main or skid
  always_comb begin
    push  = valid_in & ~s_v;
    pop   = m_v & ready_in;
    m_ld  = ~flush & push & (~m_v | pop);
    s_ld  = ~flush & push & m_v & ~pop;
    s_mv  = ~flush & s_v & pop;
    m_v_n = ~flush & (s_v | push | (m_v & ~pop));
    s_v_n = ~flush & (s_v ? ~pop : s_ld);
`ifdef RISCV_PPR_BUBBLE_ZERO_EN
    m_d_n = ~m_v_n ? '0 : s_mv ? s_d : m_ld ? data_in : m_d;
    s_d_n = ~s_v_n ? '0 : s_ld ? data_in : s_d;
`else
    m_d_n = s_mv ? s_d : m_ld ? data_in : m_d;
    s_d_n = s_ld ? data_in : s_d;
`endif
    st    = s_v ? PPR_FULL : m_v ? PPR_ONE : PPR_EMPTY;
  end
  // main and skid registers, cleared by asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m_d <= '0;
      s_d <= '0;
    end else begin
      m_v <= m_v_n;
      s_v <= s_v_n;
      m_d <= m_d_n;
      s_d <= s_d_n;
    end
  end
  a_skid_implies_main: assert property (@(posedge clk) disable iff (!rst_n) s_v |-> m_v);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) st == PPR_FULL |-> !push);
endmodule

// File: rtl/riscv_pp_skidreg.sv
// riscv_pp_skidreg: STAGES cascaded skid slices with occupancy; RISCV_PPR_BUBBLE_ZERO_EN zeroes bubble payloads
module riscv_pp_skidreg
  import riscv_ppr_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int STAGES = 1,
  parameter int OCC_W  = ppr_occ_w(STAGES)
) (
  input  logic              i_riscv_ppr_clk,
  input  logic              i_riscv_ppr_rst_n,
  input  logic              i_riscv_ppr_valid_up,
  output logic              o_riscv_ppr_ready_up,
  input  logic [DATA_W-1:0] i_riscv_ppr_data_up,
  output logic              o_riscv_ppr_valid_dn,
  input  logic              i_riscv_ppr_ready_dn,
  output logic [DATA_W-1:0] o_riscv_ppr_data_dn,
  input  logic              i_riscv_ppr_flush,
  output logic [OCC_W-1:0]  o_riscv_ppr_occ
);
  logic [STAGES:0]   v, r;
  logic [DATA_W-1:0] d [STAGES+1];
  logic              push_up, pop_dn;
  assign v[0]      = i_riscv_ppr_valid_up;
  assign d[0]      = i_riscv_ppr_data_up;
  assign r[STAGES] = i_riscv_ppr_ready_dn;
  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    riscv_ppr_skid_slice #(.DATA_W(DATA_W)) u_slice (
      .clk      (i_riscv_ppr_clk),
      .rst_n    (i_riscv_ppr_rst_n),
      .flush    (i_riscv_ppr_flush),
      .valid_in (v[k]),
      .ready_out(r[k]),
      .data_in  (d[k]),
      .valid_out(v[k+1]),
      .ready_in (r[k+1]),
      .data_out (d[k+1])
    );
  end
  assign o_riscv_ppr_ready_up = r[0];
  assign o_riscv_ppr_valid_dn = v[STAGES];
  assign o_riscv_ppr_data_dn  = d[STAGES];
  assign push_up = v[0] & r[0];
  assign pop_dn  = v[STAGES] & r[STAGES];
  // occupancy tracks boundary transfers only; internal moves never change the total
  always_ff @(posedge i_riscv_ppr_clk or negedge i_riscv_ppr_rst_n) begin
    if (!i_riscv_ppr_rst_n) o_riscv_ppr_occ <= '0;
    else o_riscv_ppr_occ <= i_riscv_ppr_flush ? '0 : o_riscv_ppr_occ + OCC_W'(push_up) - OCC_W'(pop_dn);
  end
endmodule

// File: tb/tb_riscv_pp_skidreg.sv
// tb_riscv_pp_skidreg: scoreboard bench for one-stage and two-stage skid registers
module tb_riscv_pp_skidreg;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        v1 = 0, rd1 = 0, fl1 = 0, ru1, vd1;
  logic        v2 = 0, rd2 = 0, fl2 = 0, ru2, vd2;
  logic [63:0] d1 = '0, d2 = '0, dd1, dd2;
  logic [1:0]  oc1;
  logic [2:0]  oc2;
  logic [63:0] q1[$], q2[$];
  int          total = 0, bad = 0;
`ifdef RISCV_PPR_BUBBLE_ZERO_EN
  localparam bit BZ = 1'b1;
`else
  localparam bit BZ = 1'b0;
`endif
  always #5 clk = ~clk;

  riscv_pp_skidreg #(.DATA_W(64), .STAGES(1)) u1 (
    .i_riscv_ppr_clk(clk), .i_riscv_ppr_rst_n(rst_n),
    .i_riscv_ppr_valid_up(v1), .o_riscv_ppr_ready_up(ru1), .i_riscv_ppr_data_up(d1),
    .o_riscv_ppr_valid_dn(vd1), .i_riscv_ppr_ready_dn(rd1), .o_riscv_ppr_data_dn(dd1),
    .i_riscv_ppr_flush(fl1), .o_riscv_ppr_occ(oc1)
  );
  riscv_pp_skidreg #(.DATA_W(64), .STAGES(2)) u2 (
    .i_riscv_ppr_clk(clk), .i_riscv_ppr_rst_n(rst_n),
    .i_riscv_ppr_valid_up(v2), .o_riscv_ppr_ready_up(ru2), .i_riscv_ppr_data_up(d2),
    .o_riscv_ppr_valid_dn(vd2), .i_riscv_ppr_ready_dn(rd2), .o_riscv_ppr_data_dn(dd2),
    .i_riscv_ppr_flush(fl2), .o_riscv_ppr_occ(oc2)
  );

  task automatic step(input int u, input logic v, input logic [63:0] d, input logic rd, input logic fl);
    logic        vd, ru;
    logic [63:0] dd, exp;
    logic [31:0] occ;
    int          sz;
    if (u == 1) begin v1 = v; d1 = d; rd1 = rd; fl1 = fl; end
    else begin v2 = v; d2 = d; rd2 = rd; fl2 = fl; end
    #1;
    vd = (u == 1) ? vd1 : vd2;
    dd = (u == 1) ? dd1 : dd2;
    ru = (u == 1) ? ru1 : ru2;
    if (vd && rd) begin
      total++;
      sz = (u == 1) ? q1.size() : q2.size();
      if (sz == 0) begin
        bad++;
        $display("FAIL pop_unexpected u%0d got=%h required=none", u, dd);
      end else begin
        if (u == 1) exp = q1.pop_front();
        else exp = q2.pop_front();
        if (dd !== exp) begin
          bad++;
          $display("FAIL pop_data u%0d got=%h required=%h", u, dd, exp);
        end
      end
    end
    if (u == 1) begin
      if (fl) q1.delete();
      else if (v && ru) q1.push_back(d);
    end else begin
      if (fl) q2.delete();
      else if (v && ru) q2.push_back(d);
    end
    @(posedge clk);
    #1;
    if (u == 1) begin v1 = 0; rd1 = 0; fl1 = 0; end
    else begin v2 = 0; rd2 = 0; fl2 = 0; end
    @(negedge clk);
    occ = (u == 1) ? 32'(oc1) : 32'(oc2);
    sz  = (u == 1) ? q1.size() : q2.size();
    total++;
    if (occ !== 32'(sz)) begin
      bad++;
      $display("FAIL occ u%0d got=%0d required=%0d", u, occ, sz);
    end
  endtask

  task automatic test_reset();
    #12;
    total += 2;
    if ({ru1, vd1, dd1, oc1} !== {1'b1, 1'b0, 64'h0, 2'b0}) begin
      bad++;
      $display("FAIL reset_s1 got=%b/%b/%h/%0d required=1/0/0/0", ru1, vd1, dd1, oc1);
    end
    if ({ru2, vd2, dd2, oc2} !== {1'b1, 1'b0, 64'h0, 3'b0}) begin
      bad++;
      $display("FAIL reset_s2 got=%b/%b/%h/%0d required=1/0/0/0", ru2, vd2, dd2, oc2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 3; i++) begin
      step(1, 1, 64'(i), 1, 0);
      total++;
      if (vd1 !== 1'b1 || dd1 !== 64'(i) || ru1 !== 1'b1) begin
        bad++;
        $display("FAIL stream v=%b d=%h r=%b required=1/%h/1", vd1, dd1, ru1, 64'(i));
      end
    end
    step(1, 0, 0, 1, 0);
  endtask

  task automatic test_back_pressure();
    for (int i = 0; i < 5; i++) begin
      step(2, 1, 64'hA + 64'(i), 0, 0);
      if (i >= 3) begin
        total++;
        if (ru2 !== 1'b0 || oc2 !== 3'd4) begin
          bad++;
          $display("FAIL bp_full r=%b occ=%0d required=0/4", ru2, oc2);
        end
      end
    end
    for (int i = 0; i < 5; i++) step(2, 0, 0, 1, 0);
    total++;
    if (q2.size() != 0 || vd2 !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain left=%0d v=%b required=0/0", q2.size(), vd2);
    end
  endtask

  task automatic test_skid_move();
    step(1, 1, 64'h11, 0, 0);
    step(1, 1, 64'h22, 0, 0);
    total++;
    if (ru1 !== 1'b0) begin
      bad++;
      $display("FAIL skid_full r=%b required=0", ru1);
    end
    step(1, 0, 0, 1, 0);
    total++;
    if (vd1 !== 1'b1 || dd1 !== 64'h22 || ru1 !== 1'b1 || oc1 !== 2'd1) begin
      bad++;
      $display("FAIL skid_move v=%b d=%h r=%b occ=%0d required=1/22/1/1", vd1, dd1, ru1, oc1);
    end
  endtask

  task automatic test_bubble();
    step(1, 0, 0, 1, 0);
    total++;
    if (vd1 !== 1'b0 || dd1 !== (BZ ? 64'h0 : 64'h22)) begin
      bad++;
      $display("FAIL bubble_22 v=%b d=%h required=0/%h", vd1, dd1, BZ ? 64'h0 : 64'h22);
    end
    step(1, 1, 64'hDEAD, 0, 0);
    step(1, 0, 0, 1, 0);
    total++;
    if (vd1 !== 1'b0 || dd1 !== (BZ ? 64'h0 : 64'hDEAD)) begin
      bad++;
      $display("FAIL bubble_dead v=%b d=%h required=0/%h", vd1, dd1, BZ ? 64'h0 : 64'hDEAD);
    end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) step(2, 1, 64'(i), 0, 0);
    total++;
    if (oc2 !== 3'd3) begin
      bad++;
      $display("FAIL flush_pre occ=%0d required=3", oc2);
    end
    step(2, 1, 64'h55, 1, 1);
    total++;
    if (vd2 !== 1'b0 || oc2 !== 3'd0 || ru2 !== 1'b1) begin
      bad++;
      $display("FAIL flush v=%b occ=%0d r=%b required=0/0/1", vd2, oc2, ru2);
    end
    for (int i = 0; i < 3; i++) step(2, 0, 0, 1, 0);
  endtask

  task automatic test_async_reset();
    step(2, 1, 64'h61, 0, 0);
    step(2, 1, 64'h62, 0, 0);
    total++;
    if (oc2 !== 3'd2) begin
      bad++;
      $display("FAIL ar_pre occ=%0d required=2", oc2);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (vd2 !== 1'b0 || oc2 !== 3'd0 || dd2 !== 64'h0) begin
      bad++;
      $display("FAIL ar_now v=%b occ=%0d d=%h required=0/0/0", vd2, oc2, dd2);
    end
    q1.delete();
    q2.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(2, 1, 64'h77, 1, 0);
    step(2, 0, 0, 1, 0);
    total++;
    if (vd2 !== 1'b1 || dd2 !== 64'h77) begin
      bad++;
      $display("FAIL ar_after v=%b d=%h required=1/77", vd2, dd2);
    end
    step(2, 0, 0, 1, 0);
    total++;
    if (q2.size() != 0 || vd2 !== 1'b0) begin
      bad++;
      $display("FAIL ar_drain left=%0d v=%b required=0/0", q2.size(), vd2);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_skid_move();
    test_bubble();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/riscv_pp_skidreg.md
Name: riscv_pp_skidreg

Overview:
Parametrised successor to the fixed-field inter-stage pipeline registers. Carries an opaque DATA_W-bit payload through STAGES cascaded register slices, each a 2-entry skid buffer.
- Uses valid/ready handshakes in both directions, with a synchronous flush.
- No combinational path from downstream ready to upstream ready.
- Used between RV64IMC pipeline stages (e.g. MEM->WB) once multi-cycle units can back-pressure.

Parameters:
DATA_W, 64, payload width in bits (>=1)
STAGES, 1, number of cascaded skid slices (>=1); nominal latency in cycles
OCC_W, $clog2(2*STAGES+1), width of the occupancy output (derived; do not override)

Ports:
i_riscv_ppr_clk  in  1  clock, rising edge
i_riscv_ppr_rst_n  in  1  reset, asynchronous assert, active-low
i_riscv_ppr_valid_up  in  1  upstream has payload
o_riscv_ppr_ready_up  out  1  slice 0 can accept
i_riscv_ppr_data_up  in  DATA_W  upstream payload
o_riscv_ppr_valid_dn  out  1  last slice holds payload
i_riscv_ppr_ready_dn  in  1  downstream accepts
o_riscv_ppr_data_dn  out  DATA_W  payload to downstream
i_riscv_ppr_flush  in  1  synchronous kill of all in-flight entries
o_riscv_ppr_occ  out  OCC_W  total valid entries across all slices

Behaviour:
- Reset, while i_riscv_ppr_rst_n=0:
  - all valid bits 0; all payload registers 0
  - o_riscv_ppr_ready_up=1; o_riscv_ppr_valid_dn=0; o_riscv_ppr_data_dn=0; o_riscv_ppr_occ=0
- Per slice: main register (m_v, m_d) and skid register (s_v, s_d).
  - ready_out = ~s_v, taken directly from a flop.
  - valid_out = m_v; data_out = m_d.
- push = valid_in & ready_out; pop = m_v & ready_in.
- Slice states: EMPTY (m_v=0, s_v=0), ONE (m_v=1, s_v=0), FULL (m_v=1, s_v=1).
- EMPTY:
  - push -> ONE, m_d<=data_in
  - otherwise stay
- ONE:
  - push&pop -> ONE, m_d<=data_in
  - push&~pop -> FULL, s_d<=data_in
  - ~push&pop -> EMPTY
  - neither -> hold
- FULL: push impossible (ready_out=0).
  - pop -> ONE, m_d<=s_d
  - otherwise hold
- Cascade: slice k valid_out/data_out feeds slice k+1 valid_in/data_in; slice k+1 ready_out feeds slice k ready_in.
- Latency and throughput:
  - data accepted at edge N appears on o_riscv_ppr_data_dn after edge N+STAGES-1 when downstream never stalls.
  - full throughput: 1 transfer per cycle.
- Ordering: strictly FIFO; no drop or duplication except by flush.
- Capacity: 2*STAGES entries. o_riscv_ppr_ready_up falls only when slice 0 is FULL.
- Flush (highest priority): at the edge where i_riscv_ppr_flush=1:
  - every m_v and s_v clears; a simultaneous push is discarded.
  - a simultaneous pop still counts as a transfer to downstream, since valid_dn was already 1.
  - next cycle: valid_dn=0, ready_up=1, occ=0.
  - payload registers hold their value unless RISCV_PPR_BUBBLE_ZERO_EN is defined.
- Bubbles: valid_in=0 while ready_out=1 leaves m_d unchanged. Downstream must qualify data with valid_dn.
- occ: registered sum of all m_v+s_v; updates on the same edge as the state change; never exceeds 2*STAGES.
- Async reset mid-transfer: all in-flight data is lost immediately; no handshake completes in that cycle.

Optional Feature:
- Macro RISCV_PPR_BUBBLE_ZERO_EN.
- Defined:
  - any register whose valid bit is 0 after an edge (pop-to-empty or flush) has its payload cleared to 0.
  - o_riscv_ppr_data_dn is therefore 0 whenever valid_dn=0.
  - matches the zeroed-on-reset behaviour of the legacy stage registers for waveform and trace readability.
- Undefined: payload registers load only on push or skid->main move; stale data stays visible when valid=0. Fewer enables, lower power.

Decomposition:
- Package riscv_ppr_pkg:
  - typedef enum logic [1:0] ppr_state_e {PPR_EMPTY, PPR_ONE, PPR_FULL}, used for assertions and debug only
  - localparam PPR_SLICE_CAP=2
  - function ppr_occ_w(stages) returning the occupancy width
- One natural sub-module: riscv_ppr_skid_slice (DATA_W param; one main+skid pair, local ready/valid, flush input).
- Top riscv_pp_skidreg:
  - generate-loop of STAGES slices
  - occupancy adder/counter
  - output muxing

Test Plan:
- Reset then stream, STAGES=1, DATA_W=64, ready_dn=1: push 0x1,0x2,0x3 on consecutive cycles -> data_dn shows 0x1,0x2,0x3 one cycle after each acceptance; ready_up stays 1; occ stays at 1 during the stream.
- Back-pressure, STAGES=2: ready_dn=0, push 0xA..0xE -> 4 accepted, ready_up=0 on the cycle after the 4th accept, occ=4. Release ready_dn -> output 0xA,0xB,0xC,0xD in order, with no loss.
- Skid move, STAGES=1: slice FULL with m=0x11, s=0x22; ready_dn=1 for one cycle -> data_dn=0x22 next cycle, ready_up=1, occ=1.
- Flush with simultaneous push and pop, STAGES=2, occ=3: flush=1, valid_up=1 data 0x55, ready_dn=1 -> head consumed; next cycle valid_dn=0, occ=0, ready_up=1. 0x55 never appears.
- Async reset mid-stream: drop rst_n between edges while occ=2 -> valid_dn=0, occ=0, data_dn=0 immediately. After release, the first push 0x77 emerges normally.
- RISCV_PPR_BUBBLE_ZERO_EN: build with and without the macro. Pop the last entry 0xDEAD with no new push -> data_dn=0 with the macro, 0xDEAD without; valid_dn=0 in both.
